// File: rtl/pe_sched_pkg.sv
// Shared types and default sizing for the PE row scheduler.
// Contents: per-PE lifecycle enum, load/drain FSM state enums, and the
// default job geometry used by the interface, top and drain sub-module.
package pe_sched_pkg;

    localparam int unsigned DEF_NUM_PE   = 4;
    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned DEF_FILT_LEN = 3;
    localparam int unsigned DEF_IMAP_LEN = 5;
    localparam int unsigned DEF_OUT_LEN  = DEF_IMAP_LEN - DEF_FILT_LEN + 1;

    typedef enum logic [1:0] {
        PE_FREE    = 2'd0,
        PE_LOADING = 2'd1,
        PE_RUNNING = 2'd2,
        PE_DONE    = 2'd3
    } pe_state_t;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_START = 2'd2
    } load_state_t;

    typedef enum logic {
        DR_IDLE  = 1'b0,
        DR_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/pe_row_sched_if.sv
// Bundle of the job input stream, PE-bank load/start/done/readback bus and
// psum output stream of the scheduler.
// master: scheduler side (drives in_ready, pe_load_*, pe_start, pe_rd_idx,
//         out_valid/out_data/out_pe/out_last, err).
// slave : environment side (drives in_valid/in_data, pe_done, pe_psum,
//         out_ready).
interface pe_row_sched_if
    import pe_sched_pkg::*;
#(
    parameter int unsigned NUM_PE = DEF_NUM_PE,
    parameter int unsigned DW     = DEF_DW
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic [NUM_PE-1:0]    pe_load_en;
    logic                 pe_load_sel;
    logic [3:0]           pe_load_idx;
    logic [DW-1:0]        pe_load_data;
    logic [NUM_PE-1:0]    pe_start;
    logic [NUM_PE-1:0]    pe_done;
    logic [3:0]           pe_rd_idx;
    logic [NUM_PE*DW-1:0] pe_psum;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [2:0]           out_pe;
    logic                 out_last;
    logic                 err;

    modport master (
        input  in_valid, in_data, pe_done, pe_psum, out_ready,
        output in_ready, pe_load_en, pe_load_sel, pe_load_idx, pe_load_data,
               pe_start, pe_rd_idx, out_valid, out_data, out_pe, out_last, err
    );

    modport slave (
        output in_valid, in_data, pe_done, pe_psum, out_ready,
        input  in_ready, pe_load_en, pe_load_sel, pe_load_idx, pe_load_data,
               pe_start, pe_rd_idx, out_valid, out_data, out_pe, out_last, err
    );
endinterface

// File: rtl/pe_sched_drain.sv
// Drain side of the scheduler: walks PEs in issue order, waits for the PE at
// drain_ptr to be DONE, then streams its OUT_LEN psums over valid/ready.
// Ports: pe_is_done (per-PE DONE flags), pe_psum (all PE readback slices),
// out_ready in; pe_rd_idx, out_valid/out_data/out_pe/out_last, and free_c
// (one-cycle one-hot release of the drained PE) out.
module pe_sched_drain
    import pe_sched_pkg::*;
#(
    parameter int unsigned NUM_PE  = DEF_NUM_PE,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned OUT_LEN = DEF_OUT_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PE-1:0]    pe_is_done,
    input  logic [NUM_PE*DW-1:0] pe_psum,
    input  logic                 out_ready,
    output logic [3:0]           pe_rd_idx,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [2:0]           out_pe,
    output logic                 out_last,
    output logic [NUM_PE-1:0]    free_c
);
    localparam int unsigned PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    drain_state_t     state_q, state_d;
    logic [PTR_W-1:0] drain_ptr_q, drain_ptr_d;
    logic [3:0]       rd_idx_q, rd_idx_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DR_IDLE;
            drain_ptr_q <= '0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_ptr_q <= drain_ptr_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

    // Next state: one job at a time, strictly in issue order
    always_comb begin
        state_d     = state_q;
        drain_ptr_d = drain_ptr_q;
        rd_idx_d    = rd_idx_q;
        free_c      = '0;
        case (state_q)
            DR_IDLE: begin
                rd_idx_d = '0;
                if (pe_is_done[drain_ptr_q]) state_d = DR_DRAIN;
            end
            DR_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == 4'(OUT_LEN - 1)) begin
                        free_c      = NUM_PE'(1) << drain_ptr_q;
                        drain_ptr_d = (drain_ptr_q == PTR_W'(NUM_PE - 1)) ?
                                      '0 : drain_ptr_q + PTR_W'(1);
                        rd_idx_d    = '0;
                        state_d     = DR_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = DR_IDLE;
        endcase
    end

    // Psum path is a plain mux; the PE holds its psums stable until freed
    assign out_valid = (state_q == DR_DRAIN);
    assign out_data  = pe_psum[drain_ptr_q*DW +: DW];
    assign out_pe    = 3'(drain_ptr_q);
    assign out_last  = out_valid && (rd_idx_q == 4'(OUT_LEN - 1));
    assign pe_rd_idx = rd_idx_q;

endmodule

// File: rtl/pe_row_sched.sv
// Round-robin job scheduler for a bank of NUM_PE row-convolution PEs.
// Loads each incoming job (FILT_LEN weights, then IMAP_LEN ifmap words) into
// the next free PE, pulses its start, tracks per-PE lifecycle and hands DONE
// PEs to the drain sub-module, which returns psums in issue order.
// Ports: clk, rst (async, active-low) and the bus interface (master side):
// job stream in, PE load/start/done/readback, psum stream out, sticky err.
module pe_row_sched
    import pe_sched_pkg::*;
#(
    parameter int unsigned NUM_PE   = DEF_NUM_PE,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned FILT_LEN = DEF_FILT_LEN,
    parameter int unsigned IMAP_LEN = DEF_IMAP_LEN
) (
    input logic            clk,
    input logic            rst,
    pe_row_sched_if.master bus
);
    localparam int unsigned OUT_LEN = IMAP_LEN - FILT_LEN + 1;
    localparam int unsigned JOB_LEN = FILT_LEN + IMAP_LEN;
    localparam int unsigned PTR_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned WC_W    = $clog2(JOB_LEN);

    load_state_t       ld_state_q, ld_state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [PTR_W-1:0]  issue_ptr_q, issue_ptr_d;
    logic [NUM_PE-1:0] load_en_q, load_en_d;
    logic              load_sel_q, load_sel_d;
    logic [3:0]        load_idx_q, load_idx_d;
    logic [DW-1:0]     load_data_q, load_data_d;
    logic [NUM_PE-1:0] start_q, start_d;
    logic              err_q, err_d;
    pe_state_t         pe_state_q [NUM_PE];
    pe_state_t         pe_state_d [NUM_PE];
    logic [NUM_PE-1:0] pe_is_done;
    logic [NUM_PE-1:0] free_c;
    logic [NUM_PE-1:0] issue_oh;

    assign issue_oh = NUM_PE'(1) << issue_ptr_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state_q  <= LD_IDLE;
            wc_q        <= '0;
            issue_ptr_q <= '0;
            load_en_q   <= '0;
            load_sel_q  <= 1'b0;
            load_idx_q  <= '0;
            load_data_q <= '0;
            start_q     <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) pe_state_q[k] <= PE_FREE;
        end else begin
            ld_state_q  <= ld_state_d;
            wc_q        <= wc_d;
            issue_ptr_q <= issue_ptr_d;
            load_en_q   <= load_en_d;
            load_sel_q  <= load_sel_d;
            load_idx_q  <= load_idx_d;
            load_data_q <= load_data_d;
            start_q     <= start_d;
            err_q       <= err_d;
            for (int k = 0; k < NUM_PE; k++) pe_state_q[k] <= pe_state_d[k];
        end
    end

    // Load FSM plus per-PE lifecycle updates
    always_comb begin
        ld_state_d  = ld_state_q;
        wc_d        = wc_q;
        issue_ptr_d = issue_ptr_q;
        load_en_d   = '0;
        load_sel_d  = load_sel_q;
        load_idx_d  = load_idx_q;
        load_data_d = load_data_q;
        start_d     = '0;
        err_d       = err_q;
        for (int k = 0; k < NUM_PE; k++) pe_state_d[k] = pe_state_q[k];

        case (ld_state_q)
            LD_IDLE: begin
                if (pe_state_q[issue_ptr_q] == PE_FREE) begin
                    pe_state_d[issue_ptr_q] = PE_LOADING;
                    wc_d                    = '0;
                    ld_state_d              = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (bus.in_valid) begin
                    load_en_d   = issue_oh;
                    load_sel_d  = (wc_q >= WC_W'(FILT_LEN));
                    load_idx_d  = load_sel_d ? 4'(wc_q - WC_W'(FILT_LEN)) : 4'(wc_q);
                    load_data_d = bus.in_data;
                    if (wc_q == WC_W'(JOB_LEN - 1)) begin
                        wc_d       = '0;
                        ld_state_d = LD_START;
                    end else begin
                        wc_d = wc_q + WC_W'(1);
                    end
                end
            end
            LD_START: begin
                // Registered start lands one cycle after the final load strobe
                start_d                 = issue_oh;
                pe_state_d[issue_ptr_q] = PE_RUNNING;
                issue_ptr_d             = (issue_ptr_q == PTR_W'(NUM_PE - 1)) ?
                                          '0 : issue_ptr_q + PTR_W'(1);
                ld_state_d              = LD_IDLE;
            end
            default: ld_state_d = LD_IDLE;
        endcase

        // Done is latched so a PE can finish while another one drains
        for (int k = 0; k < NUM_PE; k++) begin
            if (bus.pe_done[k]) begin
                if (pe_state_q[k] == PE_RUNNING) pe_state_d[k] = PE_DONE;
                else                             err_d         = 1'b1;
            end
            if (free_c[k]) pe_state_d[k] = PE_FREE;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PE; k++) pe_is_done[k] = (pe_state_q[k] == PE_DONE);
    end

    pe_sched_drain #(
        .NUM_PE  (NUM_PE),
        .DW      (DW),
        .OUT_LEN (OUT_LEN)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .pe_is_done (pe_is_done),
        .pe_psum    (bus.pe_psum),
        .out_ready  (bus.out_ready),
        .pe_rd_idx  (bus.pe_rd_idx),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .out_pe     (bus.out_pe),
        .out_last   (bus.out_last),
        .free_c     (free_c)
    );

    assign bus.in_ready     = (ld_state_q == LD_LOAD);
    assign bus.pe_load_en   = load_en_q;
    assign bus.pe_load_sel  = load_sel_q;
    assign bus.pe_load_idx  = load_idx_q;
    assign bus.pe_load_data = load_data_q;
    assign bus.pe_start     = start_q;
    assign bus.err          = err_q;

endmodule

// File: doc/pe_row_sched.md
Name: pe_row_sched

Overview:
- Sequences a bank of NUM_PE row-convolution PEs that share one load bus and one result path.
- Accepts a job as a stream of FILT_LEN weights followed by IMAP_LEN ifmap words, and loads the job into the next free PE in round-robin order.
- Pulses that PE's start, waits for its done, then drains its OUT_LEN psums to a valid/ready output in job-issue order.
- Sits between the global buffer/NoC and the PE bank.

Parameters:
- NUM_PE, 4, number of PEs scheduled (2..8).
- DW, 32, data width of weight, ifmap and psum words.
- FILT_LEN, 3, weights per job.
- IMAP_LEN, 5, ifmap words per job.
- OUT_LEN, IMAP_LEN-FILT_LEN+1, psums per job (derived localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  job word valid.
- in_ready  out  1  job word accepted when in_valid&in_ready.
- in_data  in  DW  weights first, then ifmap.
- pe_load_en  out  NUM_PE  one-hot write strobe to the target PE.
- pe_load_sel  out  1  0=weight, 1=ifmap.
- pe_load_idx  out  4  register index inside the PE.
- pe_load_data  out  DW  load word.
- pe_start  out  NUM_PE  one-hot 1-cycle start pulse.
- pe_done  in  NUM_PE  1-cycle done pulse per PE.
- pe_rd_idx  out  4  psum index presented to all PEs.
- pe_psum  in  NUM_PE*DW  psum[pe_rd_idx] from each PE; slice k = PE k.
- out_valid  out  1  psum valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  psum word.
- out_pe  out  3  source PE id.
- out_last  out  1  high on the final psum of a job.
- err  out  1  sticky protocol error.

Behaviour:
- Per-PE state FREE→LOADING→RUNNING→DONE→FREE, held in a NUM_PE-entry array.
- Reset: all PEs FREE; load and drain FSMs IDLE; issue and drain pointers 0. All outputs 0: in_ready, pe_load_*, pe_start, pe_rd_idx, out_valid, out_last, err.
- Reset mid-operation aborts everything. Partially loaded data inside a PE is ignored; the next job reloads it fully.
- Load FSM, IDLE:
  - Enters LOAD when PE[issue_ptr] is FREE; that PE is marked LOADING.
  - Stalls (in_ready=0) while PE[issue_ptr] is not FREE.
- Load FSM, LOAD:
  - in_ready=1; word counter wc runs 0..FILT_LEN+IMAP_LEN-1 and advances only on handshake. Gaps in in_valid hold state.
  - Each accepted word drives pe_load_* registered, one cycle later:
    - en = onehot(issue_ptr).
    - sel = (wc>=FILT_LEN).
    - idx = sel ? wc-FILT_LEN : wc.
    - data = in_data.
  - pe_load_en is 0 in every other cycle.
  - On the last accepted word: go to START; in_ready drops the next cycle.
- Load FSM, START:
  - pe_start[issue_ptr]=1 for exactly one cycle. This is the cycle after the final pe_load_en, so the final load is visible to the PE first.
  - PE marked RUNNING; issue_ptr increments modulo NUM_PE; return to IDLE.
  - Minimum job spacing: FILT_LEN+IMAP_LEN+2 cycles.
- pe_done[k]:
  - PE k RUNNING: PE k becomes DONE (flag latched, so done may arrive while another PE drains).
  - PE k not RUNNING: ignored and err set sticky.
  - Several done bits in one cycle are all latched.
- Drain FSM, IDLE: enters DRAIN when PE[drain_ptr] is DONE; pe_rd_idx=0.
- Drain FSM, DRAIN:
  - out_valid=1, out_data=pe_psum[drain_ptr slice] (combinational), out_pe=drain_ptr.
  - out_last=(pe_rd_idx==OUT_LEN-1).
  - On handshake: pe_rd_idx++.
  - On the last handshake: PE→FREE, drain_ptr++ modulo NUM_PE, pe_rd_idx→0, back to IDLE. out_valid is low for one cycle between jobs.
  - out_ready low holds all outputs stable.
- Drain order always equals issue order. A PE finishing early waits in DONE.
- Same-cycle FREE: if the drain frees PE j in the same cycle the load FSM checks PE j, the load side sees it FREE the next cycle; no bypass is required.
- The load and drain FSMs run concurrently. A PE is reloaded only from FREE, so psums stay stable while draining.

Decomposition:
- Package pe_sched_pkg:
  - pe_state_t enum FREE/LOADING/RUNNING/DONE.
  - load_state_t IDLE/LOAD/START.
  - drain_state_t IDLE/DRAIN.
  - Constants FILT_LEN, IMAP_LEN, OUT_LEN defaults.
- One sub-module: pe_sched_drain (drain FSM, psum mux, output handshake). The top holds the load FSM and the PE state array.

Test Plan:
- Bench uses a behavioural PE model with done 10 cycles after start.
- Single job, weights 1,2,3, ifmap 1,2,3,4,5, NUM_PE=4, out_ready=1:
  - pe_load_en=0001 for 8 cycles; pe_start=0001 one cycle after the last load.
  - Outputs 14,20,26, out_pe=0, out_last only on 26.
- Five back-to-back jobs:
  - Issued to PEs 0,1,2,3, then a stall (in_ready=0) until PE0 drains.
  - The fifth job then lands on PE0; outputs appear in job order.
- Model PE1 finishes before PE0 (done latencies 20/5): PE1 held DONE; output still PE0 psums first, then PE1.
- out_ready toggled 1-0-1 each cycle during a drain: no lost or duplicated psums; out_data stable while stalled.
- pe_done[2] pulsed with PE2 FREE: err=1 and stays 1; scheduling unaffected.
- rst low for 1 cycle after 4 words of a job are accepted:
  - All outputs 0.
  - The next full job loads PE0 from wc=0 and produces correct psums.
